// File: rtl/portb_change_irq_ctrl.sv
// -----------------------------------------------------------------------------
// portb_change_irq_ctrl
//
// Interrupt and change-detect controller for the PORTB bidirectional port.
// This block synchronises the resolved port value and produces two sticky
// flags in the PIC16 style:
//   - INTF : an edge on RB0/INT, with the polarity selected by intedg
//   - RBIF : a change on input-configured RB7:RB4 relative to the value
//            captured at the last PORTB read
// After reset, a short INIT phase lets the synchroniser fill with real pin
// values. This prevents reset values from raising spurious flags.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   port_in   in   resolved port value (pin value where tris=1)
//   tris      in   TRIS register; 1 = input
//   portb_rd  in   one-cycle strobe, CPU reads PORTB this cycle
//   intedg    in   1 = rising edge on RB0/INT, 0 = falling edge
//   inte      in   INTCON.INTE
//   rbie      in   INTCON.RBIE
//   gie       in   INTCON.GIE
//   intf_clr  in   CPU writes INTF=0 this cycle
//   rbif_clr  in   CPU writes RBIF=0 this cycle
//   intf      out  RB0/INT flag (sticky)
//   rbif      out  port-change flag (sticky)
//   irq       out  gie & ((intf & inte) | (rbif & rbie))
//   wake      out  (intf & inte) | (rbif & rbie), independent of gie
//
// SYNC_STAGES must be in 2..4. WIDTH must be 8.
// -----------------------------------------------------------------------------
module portb_change_irq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] port_in,
  input  logic [WIDTH-1:0] tris,
  input  logic             portb_rd,
  input  logic             intedg,
  input  logic             inte,
  input  logic             rbie,
  input  logic             gie,
  input  logic             intf_clr,
  input  logic             rbif_clr,
  output logic             intf,
  output logic             rbif,
  output logic             irq,
  output logic             wake
);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  // The counter runs 0..SYNC_STAGES. The FSM arms on the cycle after the
  // counter reaches its last value.
  localparam logic [2:0] CNT_LAST = 3'(SYNC_STAGES);

  state_e                          state_q, state_d;
  logic [2:0]                      cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                s;
  logic                            prev0_q;
  logic [3:0]                      rb_latch_q, rb_latch_d;
  logic                            intf_q, intf_d;
  logic                            rbif_q, rbif_d;
  logic                            armed;
  logic                            mismatch;
  logic                            int_edge;
  logic                            unused_bits;

  assign s     = sync_q[SYNC_STAGES-1];
  assign armed = (state_q == ST_ARMED);

  // Only RB0 and RB7:RB4 carry meaning here. The remaining bits are
  // synchronised only because the whole bus passes through one flop array.
  assign unused_bits = ^{tris[3:1], s[3:1]};

  // ---------------------------------------------------------------------------
  // FSM and change-latch next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case statement. A path
    // that leaves a signal unassigned would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    rb_latch_d = rb_latch_q;
    unique case (state_q)
      ST_INIT: begin
        // The latch tracks the pins while the synchroniser fills. This way
        // ARMED starts with no pending mismatch.
        rb_latch_d = s[7:4];
        if (cnt_q == CNT_LAST) begin
          state_d = ST_ARMED;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_ARMED: begin
        if (portb_rd) begin
          rb_latch_d = s[7:4];
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Flag set detection and flag next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // A read in the same cycle still compares against the old latch. As a
    // result, a coincident change is not lost.
    mismatch = armed && (|(tris[7:4] & (s[7:4] ^ rb_latch_q)));
    // The edge compares the pin against its own previous value. Toggling
    // intedg alone therefore cannot create an edge.
    int_edge = armed && tris[0] &&
               (intedg ? (s[0] & ~prev0_q) : (~s[0] & prev0_q));

    // A set in the same cycle as a clear wins over the clear.
    intf_d = intf_q;
    if (int_edge)      intf_d = 1'b1;
    else if (intf_clr) intf_d = 1'b0;

    rbif_d = rbif_q;
    if (mismatch)      rbif_d = 1'b1;
    else if (rbif_clr) rbif_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the synchroniser array is reset explicitly. Its stale contents
      // would otherwise reach the latch and the edge detector.
      sync_q     <= '0;
      prev0_q    <= 1'b0;
      rb_latch_q <= 4'h0;
      intf_q     <= 1'b0;
      rbif_q     <= 1'b0;
      state_q    <= ST_INIT;
      cnt_q      <= 3'd0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], port_in};
      prev0_q    <= s[0];
      rb_latch_q <= rb_latch_d;
      intf_q     <= intf_d;
      rbif_q     <= rbif_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign intf = intf_q;
  assign rbif = rbif_q;
  assign wake = (intf_q & inte) | (rbif_q & rbie);
  assign irq  = gie & wake;

endmodule

// File: tb/tb_portb_change_irq_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for portb_change_irq_ctrl.
// A cycle-level reference model keeps the history of sampled pin values and
// derives the flags from the change/edge rules. Directed vectors add
// hand-computed literal expectations at the key points.
// -----------------------------------------------------------------------------
module tb_portb_change_irq_ctrl;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] port_in;
  logic [7:0] tris;
  logic       portb_rd, intedg, inte, rbie, gie, intf_clr, rbif_clr;
  logic       intf, rbif, irq, wake;

  int checks   = 0;
  int failures = 0;

  portb_change_irq_ctrl #(.SYNC_STAGES(SS), .WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .port_in  (port_in),
    .tris     (tris),
    .portb_rd (portb_rd),
    .intedg   (intedg),
    .inte     (inte),
    .rbie     (rbie),
    .gie      (gie),
    .intf_clr (intf_clr),
    .rbif_clr (rbif_clr),
    .intf     (intf),
    .rbif     (rbif),
    .irq      (irq),
    .wake     (wake)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. m_hist[0] is the most recent pin sample.
  // After edge k, the synchronised value is the pin sample from SS-1 edges
  // earlier. The model is armed once SS+1 edges have passed since reset.
  // ---------------------------------------------------------------------------
  logic [7:0] m_hist [0:SS];
  logic [3:0] m_latch;
  logic       m_intf, m_rbif;
  int         m_edges;

  always @(posedge clk) begin
    logic [7:0] s_cur;
    logic       prev, set_rb, set_int, m_irq, m_wake;
    if (!rst_n) begin
      for (int j = 0; j <= SS; j++) m_hist[j] = 8'h00;
      m_latch = 4'h0;
      m_intf  = 1'b0;
      m_rbif  = 1'b0;
      m_edges = 0;
    end else begin
      s_cur   = m_hist[SS-1];
      prev    = m_hist[SS][0];
      set_rb  = 1'b0;
      set_int = 1'b0;
      if (m_edges >= SS + 1) begin
        for (int i = 4; i < 8; i++)
          if (tris[i] && (s_cur[i] != m_latch[i-4])) set_rb = 1'b1;
        if (tris[0])
          set_int = intedg ? (s_cur[0] && !prev) : (!s_cur[0] && prev);
        if (portb_rd) m_latch = s_cur[7:4];
      end else begin
        m_latch = s_cur[7:4];
      end
      m_intf = set_int ? 1'b1 : (intf_clr ? 1'b0 : m_intf);
      m_rbif = set_rb  ? 1'b1 : (rbif_clr ? 1'b0 : m_rbif);
      for (int j = SS; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = port_in;
      if (m_edges < 100) m_edges++;
    end
    #1;
    m_wake = (m_intf && inte) || (m_rbif && rbie);
    m_irq  = gie && m_wake;
    check("cycle_model", {28'd0, intf, rbif, irq, wake},
          {28'd0, m_intf, m_rbif, m_irq, m_wake});
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; port_in = 8'hF1; tris = 8'hFF;
    portb_rd = 0; intedg = 1; inte = 0; rbie = 0; gie = 0;
    intf_clr = 0; rbif_clr = 0;
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;

    // Reset and INIT phase
    step(1);
    check("init_flags", {intf, rbif}, 2'b00);
    step(2);
    check("init_latch", dut.rb_latch_q, 4'hF);
    check("armed_flags", {intf, rbif}, 2'b00);
    step(2);
    check("armed_no_spurious", {intf, rbif}, 2'b00);

    // RB change and read re-arm
    port_in = 8'hD1;
    step(2);
    check("rb_change_early", rbif, 1'b0);
    step(1);
    check("rb_change_set", rbif, 1'b1);
    rbif_clr = 1; step(1); rbif_clr = 0;
    check("rb_clr_no_read", rbif, 1'b1);
    step(1);
    check("rb_persist", rbif, 1'b1);
    portb_rd = 1; step(1); portb_rd = 0;
    rbif_clr = 1; step(1); rbif_clr = 0;
    check("rb_read_then_clr", rbif, 1'b0);
    step(2);
    check("rb_stays_clear", rbif, 1'b0);

    // Output-configured bits are masked
    tris = 8'h0F;
    port_in = 8'h01; step(2);
    port_in = 8'hF1; step(2);
    port_in = 8'h01; step(3);
    check("rb_output_mask", rbif, 1'b0);
    tris = 8'hFF; step(1);
    check("rb_tris_to_input", rbif, 1'b1);
    portb_rd = 1; step(1); portb_rd = 0;
    rbif_clr = 1; step(1); rbif_clr = 0;
    check("rb_cleanup", rbif, 1'b0);

    // INT edge select
    intedg = 1; port_in = 8'h00; step(4);
    check("int_fall_on_rise_sel", intf, 1'b0);
    port_in = 8'h01; step(2);
    check("int_rise_early", intf, 1'b0);
    step(1);
    check("int_rise_set", intf, 1'b1);
    intf_clr = 1; step(1); intf_clr = 0;
    check("int_clr", intf, 1'b0);
    intedg = 0; step(2);
    check("int_sel_toggle_hi", intf, 1'b0);
    port_in = 8'h00; step(3);
    check("int_fall_set", intf, 1'b1);
    intf_clr = 1; step(1); intf_clr = 0;
    check("int_clr2", intf, 1'b0);
    intedg = 1; step(3);
    check("int_sel_toggle_a", intf, 1'b0);
    intedg = 0; step(3);
    check("int_sel_toggle_b", intf, 1'b0);

    // Set/clear collision, wake and irq
    intedg = 1; port_in = 8'h01; step(2);
    intf_clr = 1; step(1); intf_clr = 0;
    check("int_set_wins", intf, 1'b1);
    inte = 1; gie = 0; #1;
    check("wake_no_gie", {wake, irq}, 2'b10);
    gie = 1; #1;
    check("irq_gie", {wake, irq}, 2'b11);

    // Async reset mid-operation
    rbie = 1;
    step(1);
    port_in = 8'hF1; step(3);
    check("rb_before_reset", rbif, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {intf, rbif, irq, wake}, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      port_in = port_in ^ 8'hF1;
    end
    @(negedge clk);
    rst_n = 1'b1; port_in = 8'h31;
    for (int c = 0; c < 3; c++) begin
      step(1);
      check("init_after_reset", {intf, rbif}, 2'b00);
    end
    step(3);
    check("armed_after_reset", {intf, rbif, irq, wake}, 4'b0000);

    step(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
